// File: rtl/rf_dbg_reader_pkg.sv
// Shared constants and types for the register-file debug reader.
// Same AW/DW/NREG values as the RF and the debug console use.
package rf_dbg_reader_pkg;

   localparam int RF_AW   = 5;
   localparam int RF_DW   = 32;
   localparam int RF_NREG = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_SEND,
      S_FIN
   } state_t;

endpackage

// File: rtl/rf_dbg_reader_if.sv
// Word stream from the debug reader to the console / UART tx path.
// Only a cycle with out_valid and out_ready both high is a transfer.
interface rf_dbg_reader_if
   import rf_dbg_reader_pkg::*;
#(
   parameter int AW = RF_AW,
   parameter int DW = RF_DW
);

   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport master (
      output out_valid,
      output out_addr,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_addr,
      input  out_data,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/rf_dbg_reader.sv
// Debug read-port master: walks the RF (or reads one register) and
// streams (addr, data, last) words over a valid/ready interface.
module rf_dbg_reader
   import rf_dbg_reader_pkg::*;
#(
   parameter int AW   = RF_AW,
   parameter int DW   = RF_DW,
   parameter int NREG = RF_NREG
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          single,
   input  logic [AW-1:0] req_addr,
   input  logic          abort,
   output logic [AW-1:0] ra_dbg,
   input  logic [DW-1:0] rd_dbg,
   rf_dbg_reader_if.master tx,
   output logic          busy,
   output logic          done
);

   // One spare bit so the final-index compare never sees a wrapped value.
   localparam logic [AW:0] LAST_IDX = (AW+1)'(NREG - 1);

   state_t      state;
   logic [AW:0] cnt;
   logic        mode_single;
   logic        xfer;

   assign ra_dbg = cnt[AW-1:0];
   assign xfer   = tx.out_valid & tx.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         mode_single  <= 1'b0;
         tx.out_valid <= 1'b0;
         tx.out_addr  <= '0;
         tx.out_data  <= '0;
         tx.out_last  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  cnt         <= single ? {1'b0, req_addr} : '0;
                  mode_single <= single;
                  busy        <= 1'b1;
                  state       <= S_READ;
               end
            end
            S_READ: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  tx.out_data  <= rd_dbg;
                  tx.out_addr  <= cnt[AW-1:0];
                  tx.out_last  <= mode_single | (cnt == LAST_IDX);
                  tx.out_valid <= 1'b1;
                  state        <= S_SEND;
               end
            end
            S_SEND: begin
               if (abort) begin
                  // A word accepted this cycle still counts; no done pulse.
                  tx.out_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= S_IDLE;
               end else if (xfer) begin
                  tx.out_valid <= 1'b0;
                  if (tx.out_last) begin
                     done  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     cnt   <= cnt + 1'b1;
                     state <= S_READ;
                  end
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_dbg_reader.sv
// Directed bench for rf_dbg_reader with a behavioural RF and a
// queue of expected words popped on each stream handshake.
module tb_rf_dbg_reader;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
      logic        l;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        single;
   logic [4:0]  req_addr;
   logic        abort;
   logic [4:0]  ra_dbg;
   logic [31:0] rd_dbg;
   logic        busy;
   logic        done;

   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [31:0] rf [32];
   logic [31:0] mdl [32];

   exp_t sb[$];
   int   n_tests;
   int   n_fail;
   int   hs;

   rf_dbg_reader_if #(.AW(5), .DW(32)) tx_if ();

   rf_dbg_reader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .single   (single),
      .req_addr (req_addr),
      .abort    (abort),
      .ra_dbg   (ra_dbg),
      .rd_dbg   (rd_dbg),
      .tx       (tx_if),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_we) rf[rf_wa] <= rf_wd;
   end

   assign rd_dbg = (ra_dbg == 5'd0) ? 32'd0 :
                   (rf_we && rf_wa == ra_dbg) ? rf_wd : rf[ra_dbg];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push_dump();
      for (int i = 0; i < 32; i++)
         sb.push_back('{a: 5'(i), d: mdl[i], l: (i == 31)});
   endtask

   task automatic push_single(input logic [4:0] ra);
      sb.push_back('{a: ra, d: mdl[ra], l: 1'b1});
   endtask

   task automatic run_op(input bit sgl, input logic [4:0] ra,
                         input bit rnd, input int abort_at,
                         input bit byp, input bit spam,
                         output int hs_at);
      int          cyc;
      bit          fin;
      bit          hold;
      bit          ab;
      logic [37:0] held;
      exp_t        e;
      hs_at = -1;
      fin   = 1'b0;
      hold  = 1'b0;
      ab    = 1'b0;
      held  = '0;
      cyc   = 0;
      @(posedge clk); #1;
      start = 1'b1; single = sgl; req_addr = ra;
      @(posedge clk); #1;
      start = 1'b0; single = 1'b0;
      while (!fin && cyc < 600) begin
         tx_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start = spam && busy;
         rf_we = 1'b0;
         if (byp && busy && !tx_if.out_valid && ra_dbg == 5'd5) begin
            rf_we = 1'b1; rf_wa = 5'd5; rf_wd = 32'hdeadbeef;
            mdl[5] = rf_wd;
         end else if (byp && tx_if.out_valid && tx_if.out_addr == 5'd4) begin
            rf_we = 1'b1; rf_wa = 5'd4; rf_wd = 32'h12345678;
            mdl[4] = rf_wd;
         end
         abort = (abort_at >= 0) && tx_if.out_valid && tx_if.out_ready &&
                 (int'(tx_if.out_addr) == abort_at);
         ab = abort;
         @(negedge clk);
         if (hold)
            chk("stable", {tx_if.out_addr, tx_if.out_data, tx_if.out_last}, held);
         hold = tx_if.out_valid && !tx_if.out_ready;
         held = {tx_if.out_addr, tx_if.out_data, tx_if.out_last};
         if (tx_if.out_valid && tx_if.out_ready) begin
            if (sb.size() == 0) begin
               chk("extra_word", 64'(sb.size()), 1);
            end else begin
               e = sb.pop_front();
               chk("addr", tx_if.out_addr, e.a);
               chk("data", tx_if.out_data, e.d);
               chk("last", tx_if.out_last, e.l);
            end
            if (tx_if.out_last || ab) begin
               hs_at = cyc + 1;
               fin   = 1'b1;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      abort = 1'b0; rf_we = 1'b0; start = 1'b0;
      if (!fin) begin
         chk("timeout", 64'(fin), 1);
      end else if (ab) begin
         chk("abort_valid", tx_if.out_valid, 0);
         chk("abort_busy", busy, 0);
         chk("abort_done", done, 0);
      end else begin
         chk("done_pulse", done, 1);
         @(posedge clk); #1;
         chk("done_clear", done, 0);
         chk("busy_after", busy, 0);
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b1; start = 1'b0; single = 1'b0; req_addr = '0;
      abort = 1'b0; tx_if.out_ready = 1'b0;
      rf_we = 1'b0; rf_wa = '0; rf_wd = '0;
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mdl[2] = 32'h00002ffc;
      mdl[3] = 32'h00001800;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {tx_if.out_valid, tx_if.out_addr, tx_if.out_data,
                          tx_if.out_last, busy, done, ra_dbg}, 0);
      for (int i = 0; i < 32; i++) begin
         rf_we = 1'b1; rf_wa = 5'(i); rf_wd = mdl[i];
         @(posedge clk); #1;
      end
      rf_we = 1'b0;
      @(negedge clk); rst = 1'b0;

      // full dump, ready held high
      push_dump();
      run_op(1'b0, 5'd0, 1'b0, -1, 1'b0, 1'b0, hs);
      chk("dump_cycles", 64'(hs), 64);
      chk("sb_empty_1", 64'(sb.size()), 0);

      // single read of x3
      push_single(5'd3);
      run_op(1'b1, 5'd3, 1'b0, -1, 1'b0, 1'b0, hs);
      chk("single_cycles", 64'(hs), 2);

      // random backpressure
      push_dump();
      run_op(1'b0, 5'd0, 1'b1, -1, 1'b0, 1'b0, hs);
      chk("sb_empty_3", 64'(sb.size()), 0);

      // abort at word 10, then a fresh dump from 0
      push_dump();
      run_op(1'b0, 5'd0, 1'b0, 10, 1'b0, 1'b0, hs);
      chk("abort_left", 64'(sb.size()), 21);
      sb.delete();
      push_dump();
      run_op(1'b0, 5'd0, 1'b0, -1, 1'b0, 1'b0, hs);
      chk("redump_cycles", 64'(hs), 64);

      // start and abort together in IDLE
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      @(posedge clk); #1;
      chk("start_abort_valid", tx_if.out_valid, 0);

      // RF bypass in the READ of x5, late write to x4
      push_dump();
      sb[5].d = 32'hdeadbeef;
      run_op(1'b0, 5'd0, 1'b0, -1, 1'b1, 1'b0, hs);
      chk("sb_empty_4", 64'(sb.size()), 0);
      push_single(5'd4);
      run_op(1'b1, 5'd4, 1'b0, -1, 1'b0, 1'b0, hs);

      // async reset with word 7 pending
      @(posedge clk); #1;
      start = 1'b1; single = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (tx_if.out_valid && tx_if.out_addr == 5'd7) break;
         tx_if.out_ready = 1'b1;
         @(posedge clk); #1;
      end
      tx_if.out_ready = 1'b0;
      chk("mid_addr", {tx_if.out_valid, tx_if.out_addr}, {1'b1, 5'd7});
      #2 rst = 1'b1;
      #1;
      chk("async_reset", {tx_if.out_valid, tx_if.out_addr, tx_if.out_data,
                          tx_if.out_last, busy, done, ra_dbg}, 0);
      @(negedge clk); rst = 1'b0;

      // single after reset, start spammed while busy
      push_single(5'd2);
      run_op(1'b1, 5'd2, 1'b0, -1, 1'b0, 1'b1, hs);
      @(posedge clk); #1;
      chk("no_restart", {busy, tx_if.out_valid}, 0);
      chk("sb_empty_6", 64'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
